risc16_memio: RTL and testbench
===============================

// Module: risc16_memio
// PURPOSE
//  Synthesizable dual-port memory + memory-mapped output subsystem for the risc16 cores.
//  Instruction port (fetch) and data port (load/store) share one word array.
//  Parametrised depth, wait states and output-register channel count.
//  ready-based handshake lets the core tolerate multi-cycle memory.
// PARAMETERS
//  DEPTH_WORDS  1024      16-bit words in array; word index = addr[15:1] mod DEPTH_WORDS
//  WAIT_CYCLES  0         extra cycles per access; latency = WAIT_CYCLES+1 (range 0..15)
//  IO_BASE      16'h0200  byte address of output register 0 (even)
//  IO_CH        3         number of 16-bit output registers, at IO_BASE+2*k
//  INIT_FILE    ""        if non-empty, $readmemh into array at elaboration
// PORTS
//  clk     in   1         clock
//  rst     in   1         synchronous active-high reset
//  iaddr   in   16        instruction byte address
//  ioe     in   1         instruction read request
//  idin    out  16        fetched word, valid when iready=1
//  iready  out  1         one-cycle fetch completion pulse
//  daddr   in   16        data byte address
//  ddout   in   16        store data from core
//  dbe     in   2         byte enables: [1]=bits 15:8 (even byte), [0]=bits 7:0 (odd byte)
//  doe     in   1         load request
//  dwe     in   1         store request
//  ddin    out  16        load data, valid when dready=1
//  dready  out  1         one-cycle load/store completion pulse
//  io_out  out  16*IO_CH  output registers concatenated, reg k at [16k+15:16k]
// BEHAVIOUR
//  Reset: clk, rst synchronous active-high. idin, ddin, io_out = 0, iready, dready = 0, both FSMs IDLE.
//   Array contents not reset.
//  Big-endian: even byte = word bits 15:8; addr[0] ignored for all accesses.
//  Per-port FSM (independent): IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: request (ioe | doe | dwe) latches addr/data/be/type, cnt<=WAIT_CYCLES;
//     WAIT_CYCLES==0 -> DONE next, else BUSY.
//   BUSY: cnt decrements each cycle; at cnt==1 -> DONE.
//   DONE: ready=1 for exactly one cycle; read data driven, store committed this cycle.
//     -> IDLE. Requests in DONE are ignored.
//   Request held high: new access accepted in the IDLE cycle after DONE.
//   Throughput is one access per WAIT_CYCLES+2 cycles.
//  Inputs changing while BUSY/DONE have no effect; latched values are used.
//  Data port, dwe & doe both high: treated as store; ddin = 0.
//  Store with dbe==2'b00 completes normally (dready pulses) but writes nothing.
//  IO decode on data port: IO_BASE <= {daddr[15:1],0} < IO_BASE+2*IO_CH.
//   Store updates enabled bytes of io_out reg only, never array.
//   Load returns reg value.
//  Instruction port never decodes IO; it always reads the array.
//  Same word: I-read and D-store both in DONE in same cycle -> idin returns old data.
//  idin/ddin hold last read value until the next DONE of that port; 0 after a store.
//  Reset mid-access: FSM -> IDLE, pending store discarded (array and io_out unchanged).
// TESTING
//  1. WAIT=0: init mem[0]=16'h1234; ioe=1, iaddr=0 -> iready at cycle +1, idin=16'h1234.
//  2. WAIT=3: store daddr=16'h0010, ddout=16'hBEEF, dbe=11 -> dready on cycle 4 only.
//     Load daddr=16'h0011 -> ddin=16'hBEEF.
//  3. Byte enables: word 0x0010=16'hBEEF; store ddout=16'h12_34, dbe=01
//     -> word reads 16'hBE34.
//  4. IO: store daddr=16'h0202, ddout=16'hA5A5 -> io_out[31:16]=16'hA5A5.
//     Array word 0x0202 unchanged. Fetch iaddr=0x0202 returns array value.
//  5. Collision WAIT=0, same word 0x0020 old=16'h0001: store 16'h0002 with simultaneous fetch
//     -> idin=16'h0001; next fetch 16'h0002.
//  6. WAIT=3: rst asserted in BUSY of a store to 0x0030 -> no dready.
//     Word 0x0030 unchanged, all outputs 0.

Source files
------------

// File: rtl/risc16_memio.sv
// Shared word memory with independent instruction and data ports plus memory-mapped
// output registers. Each port runs its own IDLE/BUSY/DONE handshake with WAIT_CYCLES of latency.

module risc16_memio_port #(
  parameter int WAIT_CYCLES = 0,
  parameter int PW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [PW-1:0] pl_in,
  output logic          fire,
  output logic          ready,
  output logic [PW-1:0] pl
);
  localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [PW-1:0] pl_q, pl_d;
  logic          ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pl_d    = pl_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        pl_d  = pl_in;
        cnt_d = WAIT_N;
        if (WAIT_N == 4'd0) begin
          state_d = DONE;
          fire    = 1'b1;
        end else begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          fire    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // fire marks the edge that performs the access; pl_d holds its payload on that edge
  assign pl    = pl_d;
  assign ready = ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pl_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pl_q    <= pl_d;
      ready_q <= fire;
    end
  end
endmodule

module risc16_memio #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [15:0] IO_BASE     = 16'h0200,
  parameter int          IO_CH       = 3,
  parameter              INIT_FILE   = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         iaddr,
  input  logic                ioe,
  output logic [15:0]         idin,
  output logic                iready,
  input  logic [15:0]         daddr,
  input  logic [15:0]         ddout,
  input  logic [1:0]          dbe,
  input  logic                doe,
  input  logic                dwe,
  output logic [15:0]         ddin,
  output logic                dready,
  output logic [16*IO_CH-1:0] io_out
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        we;
  } dreq_t;

  logic [15:0] mem [DEPTH_WORDS];

  logic                   i_fire, d_fire;
  logic [15:0]            i_addr;
  dreq_t                  d_in, d_acc;
  logic [15:0]            idin_q, idin_d, ddin_q, ddin_d;
  logic [IO_CH-1:0][15:0] io_q, io_d;
  logic [15:0]            io_off;
  logic                   io_hit, mem_we;
  logic [AW-1:0]          i_idx, d_idx;
  logic                   unused_lsb;

  function automatic logic [AW-1:0] widx(input logic [14:0] w);
    return AW'(32'(w) % DEPTH_WORDS);
  endfunction

  assign d_in.addr  = daddr;
  assign d_in.wdata = ddout;
  assign d_in.be    = dbe;
  assign d_in.we    = dwe;

  risc16_memio_port #(.WAIT_CYCLES(WAIT_CYCLES), .PW(16)) u_iport (
    .clk(clk), .rst(rst), .req(ioe), .pl_in(iaddr),
    .fire(i_fire), .ready(iready), .pl(i_addr)
  );

  risc16_memio_port #(.WAIT_CYCLES(WAIT_CYCLES), .PW($bits(dreq_t))) u_dport (
    .clk(clk), .rst(rst), .req(doe | dwe), .pl_in(d_in),
    .fire(d_fire), .ready(dready), .pl(d_acc)
  );

  // Byte offset bit 0 never selects anything: accesses are whole-word, big-endian
  assign unused_lsb = i_addr[0] ^ d_acc.addr[0];
  assign i_idx      = widx(i_addr[15:1]);
  assign d_idx      = widx(d_acc.addr[15:1]);
  // Unsigned wrap makes addresses below IO_BASE land far above IO_CH
  assign io_off     = {1'b0, d_acc.addr[15:1]} - {1'b0, IO_BASE[15:1]};
  assign io_hit     = io_off < 16'(IO_CH);

  always_comb begin
    idin_d = idin_q;
    ddin_d = ddin_q;
    io_d   = io_q;
    mem_we = 1'b0;
    if (i_fire) idin_d = mem[i_idx];
    if (d_fire) begin
      if (d_acc.we) begin
        ddin_d = '0;
        mem_we = !io_hit;
        for (int k = 0; k < IO_CH; k++) begin
          if (io_hit && io_off == 16'(k)) begin
            if (d_acc.be[1]) io_d[k][15:8] = d_acc.wdata[15:8];
            if (d_acc.be[0]) io_d[k][7:0]  = d_acc.wdata[7:0];
          end
        end
      end else begin
        ddin_d = mem[d_idx];
        for (int k = 0; k < IO_CH; k++) begin
          if (io_hit && io_off == 16'(k)) ddin_d = io_q[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idin_q <= '0;
      ddin_q <= '0;
      io_q   <= '0;
    end else begin
      idin_q <= idin_d;
      ddin_q <= ddin_d;
      io_q   <= io_d;
    end
  end

  // Same-edge fetch of a word being stored sees the pre-store contents
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      if (d_acc.be[1]) mem[d_idx][15:8] <= d_acc.wdata[15:8];
      if (d_acc.be[0]) mem[d_idx][7:0]  <= d_acc.wdata[7:0];
    end
  end

  assign idin   = idin_q;
  assign ddin   = ddin_q;
  assign io_out = io_q;
endmodule

// File: tb/tb_risc16_memio.sv
// Randomized + directed bench for risc16_memio: two instances (WAIT 0 and WAIT 3)
// checked against a transaction-level model of memory, IO registers and output holds.

module tb_risc16_memio;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic [15:0] iaddr  [2];
  logic [15:0] idin   [2];
  logic        ioe    [2];
  logic        iready [2];
  logic [15:0] daddr  [2];
  logic [15:0] ddout  [2];
  logic [1:0]  dbe    [2];
  logic        doe    [2];
  logic        dwe    [2];
  logic [15:0] ddin   [2];
  logic        dready [2];
  logic [47:0] io_out [2];

  risc16_memio #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .IO_BASE(16'h0200), .IO_CH(3), .INIT_FILE("")) u_dut0 (
    .clk(clk), .rst(rst[0]), .iaddr(iaddr[0]), .ioe(ioe[0]), .idin(idin[0]), .iready(iready[0]),
    .daddr(daddr[0]), .ddout(ddout[0]), .dbe(dbe[0]), .doe(doe[0]), .dwe(dwe[0]),
    .ddin(ddin[0]), .dready(dready[0]), .io_out(io_out[0])
  );

  risc16_memio #(.DEPTH_WORDS(128), .WAIT_CYCLES(3), .IO_BASE(16'h0200), .IO_CH(3), .INIT_FILE("")) u_dut3 (
    .clk(clk), .rst(rst[1]), .iaddr(iaddr[1]), .ioe(ioe[1]), .idin(idin[1]), .iready(iready[1]),
    .daddr(daddr[1]), .ddout(ddout[1]), .dbe(dbe[1]), .doe(doe[1]), .dwe(dwe[1]),
    .ddin(ddin[1]), .dready(dready[1]), .io_out(io_out[1])
  );

  // Reference model state
  logic [15:0] mem_m  [2][256];
  logic [15:0] io_m   [2][3];
  logic [15:0] idin_m [2];
  logic [15:0] ddin_m [2];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int waitc(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int depth(input int d);
    return (d == 0) ? 256 : 128;
  endfunction

  function automatic int widx(input int d, input logic [15:0] a);
    return int'(a[15:1]) % depth(d);
  endfunction

  function automatic bit is_io(input logic [15:0] a);
    int b;
    b = int'(a) & 32'hFFFE;
    return (b >= 32'h200) && (b < 32'h206);
  endfunction

  function automatic int io_k(input logic [15:0] a);
    return ((int'(a) & 32'hFFFE) - 32'h200) / 2;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] be);
    return {be[1] ? nw[15:8] : old[15:8], be[0] ? nw[7:0] : old[7:0]};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 2))
      0:       return 16'($urandom_range(0, 16'h003F));
      1:       return 16'($urandom_range(16'h01F8, 16'h020F));
      default: return 16'($urandom_range(16'h0400, 16'h043F));
    endcase
  endfunction

  function automatic logic [47:0] io_exp(input int d);
    return {io_m[d][2], io_m[d][1], io_m[d][0]};
  endfunction

  task automatic clear_outputs_model(input int d);
    idin_m[d] = '0;
    ddin_m[d] = '0;
    for (int k = 0; k < 3; k++) io_m[d][k] = '0;
  endtask

  // One access on fetch and/or data port issued in the same cycle, inputs scrambled after acceptance
  task automatic access(input int d, input bit ireq, input logic [15:0] ia,
                        input bit lreq, input bit sreq, input logic [15:0] da,
                        input logic [15:0] dd, input logic [1:0] be, input string tag);
    logic [15:0] exp_i, exp_d, got_i, got_d, ipat, dpat;
    int lat;
    lat   = waitc(d) + 1;
    exp_i = ireq ? mem_m[d][widx(d, ia)] : idin_m[d];
    exp_d = ddin_m[d];
    if (sreq) begin
      exp_d = '0;
      if (is_io(da)) io_m[d][io_k(da)] = merge(io_m[d][io_k(da)], dd, be);
      else           mem_m[d][widx(d, da)] = merge(mem_m[d][widx(d, da)], dd, be);
    end else if (lreq) begin
      exp_d = is_io(da) ? io_m[d][io_k(da)] : mem_m[d][widx(d, da)];
    end
    @(negedge clk);
    iaddr[d] = ia; ioe[d] = ireq;
    daddr[d] = da; ddout[d] = dd; dbe[d] = be; doe[d] = lreq; dwe[d] = sreq;
    ipat = '0; dpat = '0; got_i = '0; got_d = '0;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      ipat[k] = iready[d];
      dpat[k] = dready[d];
      if (k == lat) begin
        got_i = idin[d]; got_d = ddin[d];
        ioe[d] = 1'b0; doe[d] = 1'b0; dwe[d] = 1'b0;
      end else if (k < lat) begin
        iaddr[d] = 16'($urandom); daddr[d] = 16'($urandom);
        ddout[d] = 16'($urandom); dbe[d] = 2'($urandom);
      end
    end
    chk({tag, "_irdy"}, 64'(ipat), ireq ? 64'(16'd1 << lat) : 64'd0);
    chk({tag, "_drdy"}, 64'(dpat), (lreq | sreq) ? 64'(16'd1 << lat) : 64'd0);
    chk({tag, "_idin"}, 64'(got_i), 64'(exp_i));
    chk({tag, "_ddin"}, 64'(got_d), 64'(exp_d));
    chk({tag, "_io"}, 64'(io_out[d]), 64'(io_exp(d)));
    idin_m[d] = exp_i;
    ddin_m[d] = exp_d;
  endtask

  // Fetch request held high: one completion every WAIT+2 cycles
  task automatic held_fetch(input int d);
    int cnt, n;
    cnt = 0;
    n   = 4 * (waitc(d) + 2);
    @(negedge clk);
    iaddr[d] = 16'h0004; ioe[d] = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (iready[d]) cnt++;
    end
    ioe[d] = 1'b0;
    idin_m[d] = mem_m[d][widx(d, 16'h0004)];
    chk("held_cnt", 64'(cnt), 64'd4);
    chk("held_idin", 64'(idin[d]), 64'(idin_m[d]));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [15:0] a, dd;
    bit ir, lr, sr;
    int seen;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; iaddr[d] = '0; ioe[d] = 1'b0; daddr[d] = '0; ddout[d] = '0;
      dbe[d] = '0; doe[d] = 1'b0; dwe[d] = 1'b0;
      clear_outputs_model(d);
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_idin", 64'(idin[d]), 64'd0);
      chk("rst_ddin", 64'(ddin[d]), 64'd0);
      chk("rst_io", 64'(io_out[d]), 64'd0);
      chk("rst_rdy", 64'({iready[d], dready[d]}), 64'd0);
      rst[d] = 1'b0;
    end

    // Preload every word the random traffic can reach
    for (int d = 0; d < 2; d++) begin
      for (int b = 0; b < 16'h40; b += 2) access(d, 0, 0, 0, 1, 16'(b), 16'($urandom), 2'b11, "init");
      for (int b = 16'h1F8; b < 16'h200; b += 2) access(d, 0, 0, 0, 1, 16'(b), 16'($urandom), 2'b11, "init");
    end

    access(0, 0, 0, 0, 1, 16'h0000, 16'h1234, 2'b11, "t1st");
    access(0, 1, 16'h0000, 0, 0, 0, 0, 2'b00, "t1");
    chk("t1_const", 64'(idin[0]), 64'h1234);

    access(1, 0, 0, 0, 1, 16'h0010, 16'hBEEF, 2'b11, "t2st");
    access(1, 0, 0, 1, 0, 16'h0011, 0, 2'b00, "t2ld");
    chk("t2_const", 64'(ddin[1]), 64'hBEEF);

    access(1, 0, 0, 0, 1, 16'h0010, 16'h1234, 2'b01, "t3st");
    access(1, 0, 0, 1, 0, 16'h0010, 0, 2'b00, "t3ld");
    chk("t3_const", 64'(ddin[1]), 64'hBE34);

    access(0, 0, 0, 0, 1, 16'h0202, 16'hA5A5, 2'b11, "t4st");
    chk("t4_const", 64'(io_out[0][31:16]), 64'hA5A5);
    access(0, 1, 16'h0202, 1, 0, 16'h0202, 0, 2'b00, "t4rd");
    chk("t4_ld", 64'(ddin[0]), 64'hA5A5);

    access(0, 0, 0, 0, 1, 16'h0020, 16'h0001, 2'b11, "t5init");
    access(0, 1, 16'h0020, 0, 1, 16'h0020, 16'h0002, 2'b11, "t5col");
    chk("t5_old", 64'(idin[0]), 64'h0001);
    access(0, 1, 16'h0020, 0, 0, 0, 0, 2'b00, "t5new");
    chk("t5_new", 64'(idin[0]), 64'h0002);

    access(1, 0, 0, 0, 1, 16'h0000, 16'h0000, 2'b00, "be00");
    access(1, 0, 0, 1, 1, 16'h0014, 16'h7777, 2'b10, "both");

    // Reset during BUSY of a store: nothing committed, outputs cleared
    access(1, 0, 0, 0, 1, 16'h0030, 16'h1111, 2'b11, "t6init");
    access(1, 0, 0, 0, 1, 16'h0204, 16'h5A5A, 2'b11, "t6io");
    seen = 0;
    @(negedge clk);
    daddr[1] = 16'h0030; ddout[1] = 16'hDEAD; dbe[1] = 2'b11; dwe[1] = 1'b1;
    @(negedge clk); seen += int'(dready[1]); dwe[1] = 1'b0;
    @(negedge clk); seen += int'(dready[1]); rst[1] = 1'b1;
    @(negedge clk); seen += int'(dready[1]);
    @(negedge clk); seen += int'(dready[1]);
    chk("t6_idin", 64'(idin[1]), 64'd0);
    chk("t6_ddin", 64'(ddin[1]), 64'd0);
    chk("t6_io", 64'(io_out[1]), 64'd0);
    rst[1] = 1'b0;
    @(negedge clk); seen += int'(dready[1]);
    chk("t6_nordy", 64'(seen), 64'd0);
    clear_outputs_model(1);
    access(1, 0, 0, 1, 0, 16'h0030, 0, 2'b00, "t6ld");
    chk("t6_const", 64'(ddin[1]), 64'h1111);

    held_fetch(0);
    held_fetch(1);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        ir = 1'($urandom); lr = 1'($urandom); sr = 1'($urandom);
        if (!(ir | lr | sr)) ir = 1'b1;
        a  = pick();
        dd = 16'($urandom);
        access(d, ir, pick(), lr, sr, a, dd, 2'($urandom), "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
